// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the multi-mode LED controller.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF        = 2'd0,
        MODE_ON         = 2'd1,
        MODE_BLINK_SLOW = 2'd2,
        MODE_BLINK_FAST = 2'd3
    } mode_t;

    // Successor in the press cycle OFF -> ON -> BLINK_SLOW -> BLINK_FAST -> OFF.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_OFF:        return MODE_ON;
            MODE_ON:         return MODE_BLINK_SLOW;
            MODE_BLINK_SLOW: return MODE_BLINK_FAST;
            default:         return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/blink_prescaler.sv
// Free-running blink prescaler: counts 0..HALF_CYCLES-1 and flips a phase
// bit on every wrap. The phase output is the value the phase register takes
// at the coming clock edge, so registers loaded from it at that edge stay in
// step with the stored phase.
module blink_prescaler #(
    parameter int unsigned HALF_CYCLES = 12_500_000
) (
    input  logic clock,
    input  logic reset_s2_n,
    output logic phase
);

    localparam int unsigned CW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          phase_q;
    logic          wrap;

    // Next counter value and next phase.
    always_comb begin
        wrap    = (count_q == CW'(HALF_CYCLES - 1));
        count_d = wrap ? '0 : count_q + CW'(1);
        phase   = phase_q ^ wrap;
    end

    // Counter and phase registers.
    always_ff @(posedge clock or negedge reset_s2_n) begin
        if (!reset_s2_n) begin
            count_q <= '0;
            phase_q <= 1'b0;
        end else begin
            count_q <= count_d;
            phase_q <= phase;
        end
    end

endmodule

// File: rtl/led_mode_ctrl_generic.sv
// Multi-mode LED controller: each accepted press steps its channel through
// OFF -> ON -> BLINK_SLOW -> BLINK_FAST -> OFF, with a per-channel lockout.
// Optional macro LED_MODE_CTRL_STATUS_EN adds the mode_o status port.
module led_mode_ctrl_generic
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEVICE_COUNT     = 3,
    parameter int unsigned SLOW_HALF_CYCLES = 12_500_000,
    parameter int unsigned FAST_HALF_CYCLES = 2_500_000,
    parameter int unsigned LOCKOUT_CYCLES   = 5_000_000
) (
    input  logic                      clock,
    input  logic                      reset_s2_n,
    input  logic                      clear,
    input  logic [DEVICE_COUNT-1:0]   button_pressed_s2,
    output logic [DEVICE_COUNT-1:0]   led
`ifdef LED_MODE_CTRL_STATUS_EN
    ,
    output logic [2*DEVICE_COUNT-1:0] mode_o
`endif
);

    localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);

    logic              slow_phase;
    logic              fast_phase;
    mode_t             mode_q [DEVICE_COUNT];
    mode_t             mode_d [DEVICE_COUNT];
    logic [LW-1:0]     lock_q [DEVICE_COUNT];
    logic [LW-1:0]     lock_d [DEVICE_COUNT];
    logic [DEVICE_COUNT-1:0] accept;
    logic [DEVICE_COUNT-1:0] led_d;

    blink_prescaler #(.HALF_CYCLES(SLOW_HALF_CYCLES)) u_slow (
        .clock      (clock),
        .reset_s2_n (reset_s2_n),
        .phase      (slow_phase)
    );

    blink_prescaler #(.HALF_CYCLES(FAST_HALF_CYCLES)) u_fast (
        .clock      (clock),
        .reset_s2_n (reset_s2_n),
        .phase      (fast_phase)
    );

    // State register: per-channel mode, lockout counter and LED drive.
    always_ff @(posedge clock or negedge reset_s2_n) begin
        if (!reset_s2_n) begin
            for (int unsigned i = 0; i < DEVICE_COUNT; i++) begin
                mode_q[i] <= MODE_OFF;
                lock_q[i] <= '0;
            end
            led <= '0;
        end else begin
            for (int unsigned i = 0; i < DEVICE_COUNT; i++) begin
                mode_q[i] <= mode_d[i];
                lock_q[i] <= lock_d[i];
            end
            led <= led_d;
        end
    end

    // Next state: clear beats presses; a press is accepted only with lockout idle.
    always_comb begin
        accept = '0;
        for (int unsigned i = 0; i < DEVICE_COUNT; i++) begin
            accept[i] = button_pressed_s2[i] && (lock_q[i] == '0) && !clear;
            mode_d[i] = mode_q[i];
            lock_d[i] = lock_q[i];
            if (clear) begin
                mode_d[i] = MODE_OFF;
                lock_d[i] = '0;
            end else if (accept[i]) begin
                mode_d[i] = next_mode(mode_q[i]);
                lock_d[i] = LW'(LOCKOUT_CYCLES - 1);
            end else if (lock_q[i] != '0) begin
                lock_d[i] = lock_q[i] - LW'(1);
            end
        end
    end

    // Output decode from next-state mode so a press shows on led at the same edge.
    always_comb begin
        led_d = '0;
        for (int unsigned i = 0; i < DEVICE_COUNT; i++) begin
            case (mode_d[i])
                MODE_OFF:        led_d[i] = 1'b0;
                MODE_ON:         led_d[i] = 1'b1;
                MODE_BLINK_SLOW: led_d[i] = slow_phase;
                default:         led_d[i] = fast_phase;
            endcase
        end
    end

`ifdef LED_MODE_CTRL_STATUS_EN
    // Status view of the registered per-channel modes.
    always_comb begin
        mode_o = '0;
        for (int unsigned i = 0; i < DEVICE_COUNT; i++) begin
            mode_o[2*i +: 2] = mode_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_led_mode_ctrl_generic.sv
// Self-checking bench for led_mode_ctrl_generic (3 channels, slow 8, fast 2, lockout 4).
module tb_led_mode_ctrl_generic;

    logic       clock;
    logic       reset_s2_n;
    logic       clear;
    logic [2:0] button_pressed_s2;
    logic [2:0] led;
`ifdef LED_MODE_CTRL_STATUS_EN
    logic [5:0] mode_o;
`endif

    int checks;
    int errors;
    int edge_cnt;

    led_mode_ctrl_generic #(
        .DEVICE_COUNT     (3),
        .SLOW_HALF_CYCLES (8),
        .FAST_HALF_CYCLES (2),
        .LOCKOUT_CYCLES   (4)
    ) dut (
        .clock             (clock),
        .reset_s2_n        (reset_s2_n),
        .clear             (clear),
        .button_pressed_s2 (button_pressed_s2),
        .led               (led)
`ifdef LED_MODE_CTRL_STATUS_EN
        ,
        .mode_o            (mode_o)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] btn;
        logic       clr;
        logic [2:0] exp_led;
    } vec_t;

    // Expected blink phases after edge e (edges counted from reset release).
    function automatic logic sph(input int e);
        return ((e / 8) % 2) == 1;
    endfunction

    function automatic logic fph(input int e);
        return ((e / 2) % 2) == 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    task automatic step(input logic [2:0] b, input logic c);
        button_pressed_s2 = b;
        clear             = c;
        @(posedge clock);
        #1;
        edge_cnt++;
        button_pressed_s2 = '0;
        clear             = 1'b0;
    endtask

    task automatic do_reset();
        reset_s2_n        = 1'b0;
        button_pressed_s2 = '0;
        clear             = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_s2_n = 1'b1;
        edge_cnt   = 0;
    endtask

    vec_t vecs [15];

    initial begin
        checks = 0;
        errors = 0;
        edge_cnt = 0;

        // Directed table from a fresh reset; one entry per clock edge.
        vecs[0]  = '{3'b001, 1'b0, 3'b001}; // ch0 ON
        vecs[1]  = '{3'b001, 1'b0, 3'b001}; // locked out
        vecs[2]  = '{3'b010, 1'b0, 3'b011}; // ch1 ON
        vecs[3]  = '{3'b000, 1'b0, 3'b011};
        vecs[4]  = '{3'b001, 1'b0, 3'b010}; // ch0 SLOW, phase 0
        vecs[5]  = '{3'b010, 1'b0, 3'b010}; // ch1 locked out
        vecs[6]  = '{3'b010, 1'b0, 3'b000}; // ch1 SLOW, phase 0
        vecs[7]  = '{3'b000, 1'b0, 3'b011}; // slow phase flips at edge 8
        vecs[8]  = '{3'b100, 1'b0, 3'b111}; // ch2 ON
        vecs[9]  = '{3'b001, 1'b0, 3'b111}; // ch0 FAST, fast phase 1
        vecs[10] = '{3'b000, 1'b0, 3'b111};
        vecs[11] = '{3'b000, 1'b0, 3'b110}; // fast phase 0 at edge 12
        vecs[12] = '{3'b100, 1'b1, 3'b000}; // clear wins over press
        vecs[13] = '{3'b111, 1'b0, 3'b111}; // all accepted right after clear
        vecs[14] = '{3'b000, 1'b0, 3'b111};

        do_reset();
        check("reset_led", led, 3'b000);
        for (int k = 0; k < 15; k++) begin
            step(vecs[k].btn, vecs[k].clr);
            check($sformatf("table[%0d]", k), led, vecs[k].exp_led);
        end

        // Idle after reset: LEDs dark, shared phases toggle at 8 and 2 cycles.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            step(3'b000, 1'b0);
            check("idle_led", led, 3'b000);
            check("idle_slow_phase", dut.u_slow.phase_q, sph(edge_cnt));
            check("idle_fast_phase", dut.u_fast.phase_q, fph(edge_cnt));
        end

        // Channel 0 through the full cycle.
        step(3'b001, 1'b0);
        check("ch0_on", led, 3'b001);
        for (int k = 0; k < 5; k++) begin
            step(3'b000, 1'b0);
            check("ch0_on_hold", led, 3'b001);
        end
        step(3'b001, 1'b0);
        check("ch0_slow_enter", led, {2'b00, sph(edge_cnt)});
        for (int k = 0; k < 20; k++) begin
            step(3'b000, 1'b0);
            check("ch0_slow", led, {2'b00, sph(edge_cnt)});
        end
        step(3'b001, 1'b0);
        check("ch0_fast_enter", led, {2'b00, fph(edge_cnt)});
        for (int k = 0; k < 10; k++) begin
            step(3'b000, 1'b0);
            check("ch0_fast", led, {2'b00, fph(edge_cnt)});
        end
        step(3'b001, 1'b0);
        check("ch0_off", led, 3'b000);

        // Lockout on channel 1: four back-to-back presses count once.
        for (int k = 0; k < 4; k++) begin
            step(3'b010, 1'b0);
            check("ch1_lockout", led, 3'b010);
        end
        step(3'b010, 1'b0);
        check("ch1_after_lockout", led, {1'b0, sph(edge_cnt), 1'b0});

        // Simultaneous presses on all channels.
        do_reset();
        step(3'b111, 1'b0);
        check("all_on", led, 3'b111);
        repeat (5) step(3'b000, 1'b0);
        step(3'b111, 1'b0);
        check("all_slow", led, {3{sph(edge_cnt)}});
        repeat (5) step(3'b000, 1'b0);
        step(3'b111, 1'b0);
        check("all_fast", led, {3{fph(edge_cnt)}});
        step(3'b000, 1'b0);
        check("all_fast_2", led, {3{fph(edge_cnt)}});
        step(3'b100, 1'b1);
        check("clear_led", led, 3'b000);
        step(3'b000, 1'b0);
        check("clear_hold", led, 3'b000);
        step(3'b010, 1'b0);
        check("press_after_clear", led, 3'b010);

        // Asynchronous reset while ch0 blinks lit with lockout running.
        do_reset();
        step(3'b001, 1'b0);
        check("ar_on", led, 3'b001);
        repeat (6) step(3'b000, 1'b0);
        step(3'b001, 1'b0);
        check("ar_slow_lit", led, 3'b001);
        step(3'b000, 1'b0);
        check("ar_slow_lit_2", led, 3'b001);
        #2;
        reset_s2_n = 1'b0;
        #1;
        check("ar_async_led", led, 3'b000);
        check("ar_async_phase", dut.u_slow.phase_q, 1'b0);
        #2;
        reset_s2_n = 1'b1;
        edge_cnt   = 0;
        step(3'b001, 1'b0);
        check("ar_first_press", led, 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_mode_ctrl_generic.md
Name: led_mode_ctrl_generic

Overview:
Parametrised multi-mode LED controller for DEVICE_COUNT channels, successor to the plain toggle design. Each synchronized button press advances its channel through OFF -> ON -> BLINK_SLOW -> BLINK_FAST -> OFF. A per-channel press lockout suppresses repeated presses. Sits directly after meta_prev and drives the board LEDs.

Parameters:
DEVICE_COUNT, 3, number of buttons/LEDs (>= 1).
SLOW_HALF_CYCLES, 12_500_000, clock cycles per half-period of slow blink (2 Hz at 50 MHz); >= 1.
FAST_HALF_CYCLES, 2_500_000, clock cycles per half-period of fast blink (10 Hz); >= 1.
LOCKOUT_CYCLES, 5_000_000, cycles a channel ignores presses after an accepted press (100 ms); >= 1.

Ports:
clock  input  1  50 MHz system clock.
reset_s2_n  input  1  synchronized reset, asynchronous, active-low.
clear  input  1  synchronous clear: all channels to OFF.
button_pressed_s2  input  DEVICE_COUNT  single-cycle press pulses from meta_prev.
led  output  DEVICE_COUNT  registered LED drive, 1 = lit.

Behaviour:
- Reset (reset_s2_n low, asynchronous): all modes OFF, led = '0, lockout counters 0, both prescaler counters 0, both blink phases 0.
- Blink prescalers: free-running counters, shared by all channels. Each counts 0..HALF-1, wraps to 0, and inverts its phase bit on wrap. Phases start at 0 after reset. Channels in the same blink mode are always in sync.
- Press acceptance: bit i of button_pressed_s2 high at edge n, lockout_i == 0, clear low -> mode_i advances one step. lockout_i is loaded with LOCKOUT_CYCLES-1 at the same edge.
- Lockout: decrements by 1 per cycle while nonzero. Presses while nonzero are dropped, not queued. LOCKOUT_CYCLES = 1 means a press is accepted every cycle.
- Mode sequence: OFF -> ON -> BLINK_SLOW -> BLINK_FAST -> OFF (wraps).
- led_i register, updated each edge from next-state values:
  - OFF -> 0
  - ON -> 1
  - BLINK_SLOW -> next slow phase
  - BLINK_FAST -> next fast phase
- Latency: a press sampled at edge n is reflected on led at edge n.
- Entering a blink mode joins the current shared phase; the blink does not restart.
- clear high:
  - all modes OFF, led = '0, all lockouts 0.
  - takes priority over simultaneous presses.
  - prescalers keep running.
- Channels are fully independent; simultaneous presses on different channels are all honoured.
- Reset asserted mid-blink or mid-lockout: immediate return to reset state. Operation resumes at the first edge after release.

Optional Feature:
Macro LED_MODE_CTRL_STATUS_EN.
- Defined: adds output port mode_o [2*DEVICE_COUNT-1:0], carrying the registered mode of channel i in bits [2i+1:2i], encoded per mode_t. Reset value '0.
- Not defined: port absent; behaviour otherwise identical.

Decomposition:
- Package led_ctrl_pkg:
  - typedef enum logic[1:0] mode_t {MODE_OFF=0, MODE_ON=1, MODE_BLINK_SLOW=2, MODE_BLINK_FAST=3}.
  - function next_mode(mode_t) returning the successor.
- Sub-module blink_prescaler #(HALF_CYCLES), ports (clock, reset_s2_n, phase). Instantiated twice, slow and fast.
- Lockout width: $clog2(LOCKOUT_CYCLES+1).

Test Plan:
All scenarios use DEVICE_COUNT=3, SLOW_HALF_CYCLES=8, FAST_HALF_CYCLES=2, LOCKOUT_CYCLES=4.
- Reset, idle 40 cycles -> led == 3'b000. Internal slow phase toggles every 8 cycles, fast phase every 2.
- Pulse button[0], wait 5, pulse again, wait 5, pulse again:
  - led[0] = 1 after first pulse.
  - then toggles every 8 cycles in sync with slow phase.
  - then toggles every 2 cycles.
  - fourth accepted press -> led[0] = 0.
- Pulse button[1] on cycles 0, 1, 2, 3 -> only the first is accepted (mode ON). Pulse on cycle 4 -> accepted (BLINK_SLOW).
- Pulse all three buttons on the same edge -> led == 3'b111 on that edge.
- Channels in BLINK_FAST, clear pulsed together with button[2] -> led == 3'b000, all modes OFF. Next press on any channel is accepted immediately.
- Channel 0 in BLINK_SLOW with lockout active, assert reset_s2_n low mid-cycle -> led drops to 0 asynchronously, without waiting for a clock edge. After release, first press gives ON.
